// File: rtl/alu_muldiv.sv
// alu_muldiv: sequential RV32I ALU plus M-extension behind a valid/ready handshake, one op in flight.
// Define ALU_MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide always stays iterative.
module alu_muldiv #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero_flag,
    output logic            illegal_op
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [SHW-1:0]  cnt;

    logic            op_is_base, op_is_mul, op_is_div, op_illegal;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic            div_zero, div_ovf, take_iter;
    logic [XLEN-1:0] mag_a, mag_b, one_res;

    logic [XLEN-1:0] acc_hi, acc_lo, mcand;
    logic            neg_res, neg_rem, sel_hi, is_div_q;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] step_hi, step_lo, iter_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    function automatic logic [XLEN-1:0] base_alu(input logic [4:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = sa >>> b[SHW-1:0];
            OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign in_ready = (state == IDLE);

    always_comb begin
        op_is_base = (alu_op <= OP_SLTU);
        op_is_mul  = (alu_op[4:2] == 3'b100);
        op_is_div  = (alu_op[4:2] == 3'b101);
        op_illegal = !(op_is_base || op_is_mul || op_is_div);
        // MULH and MULHSU treat rs1 as signed, only MULH treats rs2 as signed; DIV/REM are the even div codes.
        a_signed   = (op_is_mul && (alu_op[1:0] == 2'b01 || alu_op[1:0] == 2'b10)) ||
                     (op_is_div && !alu_op[0]);
        b_signed   = (op_is_mul && alu_op[1:0] == 2'b01) || (op_is_div && !alu_op[0]);
        a_neg      = a_signed && operand_a[XLEN-1];
        b_neg      = b_signed && operand_b[XLEN-1];
        mag_a      = neg_if(operand_a, a_neg);
        mag_b      = neg_if(operand_b, b_neg);
        div_zero   = (operand_b == '0);
        div_ovf    = op_is_div && !alu_op[0] && (operand_a == INT_MIN) && (operand_b == '1);
`ifdef ALU_MULDIV_FAST_MUL_EN
        take_iter  = op_is_div && !(div_zero || div_ovf);
`else
        take_iter  = (op_is_div && !(div_zero || div_ovf)) || op_is_mul;
`endif
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;

    always_comb begin
        fast_a    = {a_signed & operand_a[XLEN-1], operand_a};
        fast_b    = {b_signed & operand_b[XLEN-1], operand_b};
        fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
    end
`endif

    always_comb begin
        if (op_is_base)
            one_res = base_alu(alu_op, operand_a, operand_b);
        else if (op_is_div)
            one_res = alu_op[1] ? (div_zero ? operand_a : '0) : (div_zero ? '1 : INT_MIN);
`ifdef ALU_MULDIV_FAST_MUL_EN
        else if (op_is_mul)
            one_res = (alu_op[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif
        else
            one_res = '0;
    end

    // One shift-add or restoring-subtract step on magnitudes; acc_hi/acc_lo double as remainder/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (is_div_q) begin
            if (!div_diff[XLEN]) begin
                step_hi = div_diff[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = div_shift[XLEN-1:0];
                step_lo = {acc_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[XLEN-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_res ? -prod : prod;
        if (is_div_q)
            iter_res = sel_hi ? neg_if(step_hi, neg_rem) : neg_if(step_lo, neg_res);
        else
            iter_res = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            acc_hi   <= '0;
            acc_lo   <= mag_a;
            mcand    <= mag_b;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            sel_hi   <= op_is_div ? alu_op[1] : (alu_op[1:0] != 2'b00);
            is_div_q <= op_is_div;
        end else if (state == BUSY) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            alu_result <= '0;
            zero_flag  <= 1'b1;
            illegal_op <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (take_iter) begin
                        state <= BUSY;
                        cnt   <= SHW'(XLEN - 1);
                    end else begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        alu_result <= one_res;
                        zero_flag  <= (one_res == '0);
                        illegal_op <= op_illegal;
                    end
                end
                BUSY: if (cnt == '0) begin
                    state      <= DONE;
                    out_valid  <= 1'b1;
                    alu_result <= iter_res;
                    zero_flag  <= (iter_res == '0);
                    illegal_op <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed, table-driven bench for alu_muldiv (XLEN=32) plus hand sequences for back-pressure, flush and reset.
module tb_alu_muldiv;

    localparam int XLEN = 32;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;
    localparam int NVEC    = 32;

    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
    localparam logic [4:0] SLL = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  SLT = 5'd8, SLTU = 5'd9;
    localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
    localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready, zero_flag, illegal_op;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] operand_a, operand_b, alu_result;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero_flag  (zero_flag),
        .illegal_op (illegal_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fire_only(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        alu_op    = 5'd0;
        operand_a = '1;
        operand_b = '1;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic ill, output int lat);
        fire_only(op, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = alu_result;
        z   = zero_flag;
        ill = illegal_op;
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        logic [31:0] res;
        logic        z, ill;
        int          lat;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; operand_a = '0; operand_b = '0;

        vecs[0]  = '{SUB,    32'h401E1042, 32'h7FFFFFFF, 32'hC01E1043, 1'b0, 1};
        vecs[1]  = '{SUB,    32'd5,        32'd5,        32'h00000000, 1'b0, 1};
        vecs[2]  = '{ADD,    32'd3,        32'd4,        32'h00000007, 1'b0, 1};
        vecs[3]  = '{AND_,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1};
        vecs[4]  = '{OR_,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1};
        vecs[5]  = '{XOR_,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1};
        vecs[6]  = '{SLL,    32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1};
        vecs[7]  = '{SRL,    32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1};
        vecs[8]  = '{SRA,    32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1};
        vecs[9]  = '{SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1};
        vecs[10] = '{SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
        vecs[11] = '{MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, MUL_LAT};
        vecs[12] = '{MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, MUL_LAT};
        vecs[13] = '{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, MUL_LAT};
        vecs[14] = '{MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, MUL_LAT};
        vecs[15] = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MUL_LAT};
        vecs[16] = '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, DIV_LAT};
        vecs[17] = '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, DIV_LAT};
        vecs[18] = '{DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 1'b0, DIV_LAT};
        vecs[19] = '{REM,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, DIV_LAT};
        vecs[20] = '{DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, DIV_LAT};
        vecs[21] = '{REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0, DIV_LAT};
        vecs[22] = '{DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1};
        vecs[23] = '{REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1};
        vecs[24] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
        vecs[25] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
        vecs[26] = '{5'd31,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1};
        vecs[27] = '{5'd12,  32'h00000005, 32'h00000006, 32'h00000000, 1'b1, 1};
        vecs[28] = '{MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MUL_LAT};
        vecs[29] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MUL_LAT};
        vecs[30] = '{DIV,    32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1};
        vecs[31] = '{REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, 1};

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", alu_result, 0);
        check("rst_zero", zero_flag, 1);
        check("rst_illegal", illegal_op, 0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, ill, lat);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_zero", i), z, (vecs[i].res == 32'd0));
            check($sformatf("v%0d_illegal", i), ill, vecs[i].ill);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            consume();
            check($sformatf("v%0d_in_ready_after", i), in_ready, 1);
            check($sformatf("v%0d_out_valid_after", i), out_valid, 0);
        end

        // Back-pressure on MULHU with new requests presented while the result waits.
        run_op(MULHU, 32'hFFFFFFFF, 32'h00000002, res, z, ill, lat);
        check("bp_result", res, 32'h00000001);
        check("bp_latency", lat, MUL_LAT);
        alu_op = ADD; operand_a = 32'd0; operand_b = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_out_valid", i), out_valid, 1);
            check($sformatf("bp%0d_result", i), alu_result, 32'h00000001);
            check($sformatf("bp%0d_zero", i), zero_flag, 0);
            check($sformatf("bp%0d_in_ready", i), in_ready, 0);
        end
        in_valid = 1'b0;
        consume();
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);

        // Flush during BUSY of a divide.
        fire_only(DIV, 32'hFFFFFFF9, 32'h00000002);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_in_ready", in_ready, 1);
        check("flush_busy_out_valid", out_valid, 0);
        watch_quiet("flush_busy_quiet", 40);
        run_op(ADD, 32'd3, 32'd4, res, z, ill, lat);
        check("flush_add_result", res, 32'd7);
        check("flush_add_latency", lat, 1);
        consume();

        // Flush wins over a same-cycle fire.
        @(negedge clk);
        alu_op = ADD; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_fire_in_ready", in_ready, 1);
        watch_quiet("flush_fire_quiet", 3);

        // Flush in DONE while the consumer accepts.
        run_op(ADD, 32'd1, 32'd1, res, z, ill, lat);
        check("flush_done_result", res, 32'd2);
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_out_valid", out_valid, 0);
        check("flush_done_in_ready", in_ready, 1);

        // Asynchronous reset pulse mid-BUSY.
        fire_only(DIVU, 32'h00000064, 32'h00000007);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy_in_ready_low", in_ready, 0);
        rst = 1'b1;
        #1;
        check("rst_busy_in_ready", in_ready, 1);
        check("rst_busy_out_valid", out_valid, 0);
        check("rst_busy_result", alu_result, 0);
        check("rst_busy_zero", zero_flag, 1);
        @(negedge clk);
        rst = 1'b0;
        watch_quiet("rst_busy_quiet", 40);
        run_op(ADD, 32'd3, 32'd4, res, z, ill, lat);
        check("rst_add_result", res, 32'd7);
        check("rst_add_zero", z, 0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
